// File: rtl/anim_pkg.sv
// Shared types and constants for the animation timing stage.
package anim_pkg;

    localparam int CNT_W      = 7;
    localparam int NUM_GHOSTS = 4;

    // Ghost bit positions in ghost_moving / ghost_eaten
    localparam int RED    = 0;
    localparam int ORANGE = 1;
    localparam int CYAN   = 2;
    localparam int PINK   = 3;

    localparam int DEF_PAC_ANIM_LEN   = 6;
    localparam int DEF_GHOST_ANIM_LEN = 6;
    localparam int DEF_DEATH_START    = 100;
    localparam int DEF_SCARED_FRAMES  = 120;

    typedef enum logic [1:0] {
        ALIVE   = 2'd0,
        DYING   = 2'd1,
        RESPAWN = 2'd2
    } anim_state_t;

    // Increment with wrap from len-1 back to 0
    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v,
                                                  input logic [CNT_W-1:0] len);
        return (v == len - 7'd1) ? 7'd0 : v + 7'd1;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame clock into the system domain and emits a
// one-cycle registered pulse three cycles after each rising edge.
module frame_tick_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic tick_o
);

    logic [2:0] sync_q;   // [0],[1] synchronizer, [2] edge-detect history
    logic       tick_q;

    // Two-flop synchronizer, delay stage, and registered rising-edge pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
            tick_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/anim_sequencer.sv
// Per-frame animation timebases: sprite animation counters, Pac-Man death
// sequence and power-pellet scared timer.
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int PAC_ANIM_LEN   = DEF_PAC_ANIM_LEN,
    parameter int GHOST_ANIM_LEN = DEF_GHOST_ANIM_LEN,
    parameter int DEATH_START    = DEF_DEATH_START,
    parameter int SCARED_FRAMES  = DEF_SCARED_FRAMES
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_clk,
    input  logic             pac_moving,
    input  logic [3:0]       ghost_moving,
    input  logic             pac_caught,
    input  logic             scared_start,
    input  logic [3:0]       ghost_eaten,
    output logic [CNT_W-1:0] animation_count,
    output logic [CNT_W-1:0] red_ghost_animation_count,
    output logic [CNT_W-1:0] orange_ghost_animation_count,
    output logic [CNT_W-1:0] cyan_ghost_animation_count,
    output logic [CNT_W-1:0] pink_ghost_animation_count,
    output logic             dying,
    output logic [CNT_W-1:0] death_time,
    output logic             is_red_scared,
    output logic             is_orange_scared,
    output logic             is_cyan_scared,
    output logic             is_pink_scared,
    output logic             respawn
);

    localparam logic [CNT_W-1:0] PAC_LEN   = CNT_W'(PAC_ANIM_LEN);
    localparam logic [CNT_W-1:0] GHOST_LEN = CNT_W'(GHOST_ANIM_LEN);
    localparam logic [CNT_W-1:0] DEATH_LD  = CNT_W'(DEATH_START);
    localparam logic [CNT_W-1:0] SCARED_LD = CNT_W'(SCARED_FRAMES);

    logic tick;

    frame_tick_sync u_tick (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .async_i(frame_clk),
        .tick_o (tick)
    );

    anim_state_t           state_q, state_d;
    logic [CNT_W-1:0]      pac_cnt_q, pac_cnt_d;
    logic [CNT_W-1:0]      death_q, death_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic [NUM_GHOSTS-1:0] scared_q, scared_d;
    logic                  dying_q, dying_d;
    logic                  respawn_q, respawn_d;

    // Sprites animate only on a tick while alive; a capture on the same
    // cycle takes precedence and freezes everything.
    logic adv;
    assign adv = tick && (state_q == ALIVE) && !pac_caught;

    // Next-state and registered-output logic for the life/death FSM
    always_comb begin
        state_d   = state_q;
        pac_cnt_d = pac_cnt_q;
        death_d   = death_q;
        timer_d   = timer_q;
        scared_d  = scared_q;
        dying_d   = 1'b0;
        respawn_d = 1'b0;
        unique case (state_q)
            ALIVE: begin
                if (pac_caught) begin
                    state_d   = DYING;
                    death_d   = DEATH_LD;
                    pac_cnt_d = '0;
                    timer_d   = '0;
                    scared_d  = '0;
                    dying_d   = 1'b1;
                end else begin
                    if (adv && pac_moving) pac_cnt_d = wrap_inc(pac_cnt_q, PAC_LEN);
                    if (scared_start) begin
                        // a load (or reload) beats both decrement and eaten pulses
                        timer_d  = SCARED_LD;
                        scared_d = '1;
                    end else begin
                        if (tick && timer_q != '0) begin
                            timer_d = timer_q - 7'd1;
                            if (timer_q == 7'd1) scared_d = '0;
                        end
                        scared_d = scared_d & ~ghost_eaten;
                    end
                end
            end
            DYING: begin
                dying_d = 1'b1;
                if (tick) begin
                    if (death_q == '0) begin
                        state_d   = RESPAWN;
                        dying_d   = 1'b0;
                        respawn_d = 1'b1;
                    end else begin
                        death_d = death_q - 7'd1;
                    end
                end
            end
            RESPAWN: state_d = ALIVE;
            default: state_d = ALIVE;
        endcase
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ALIVE;
            pac_cnt_q <= '0;
            death_q   <= '0;
            timer_q   <= '0;
            scared_q  <= '0;
            dying_q   <= 1'b0;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pac_cnt_q <= pac_cnt_d;
            death_q   <= death_d;
            timer_q   <= timer_d;
            scared_q  <= scared_d;
            dying_q   <= dying_d;
            respawn_q <= respawn_d;
        end
    end

    logic [CNT_W-1:0] ghost_cnt [NUM_GHOSTS];

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
        logic [CNT_W-1:0] cnt_q;
        // Per-ghost animation counter; holds outside ALIVE
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n)                 cnt_q <= '0;
            else if (adv && ghost_moving[g]) cnt_q <= wrap_inc(cnt_q, GHOST_LEN);
        end
        assign ghost_cnt[g] = cnt_q;
    end

    assign animation_count              = pac_cnt_q;
    assign red_ghost_animation_count    = ghost_cnt[RED];
    assign orange_ghost_animation_count = ghost_cnt[ORANGE];
    assign cyan_ghost_animation_count   = ghost_cnt[CYAN];
    assign pink_ghost_animation_count   = ghost_cnt[PINK];
    assign dying                        = dying_q;
    assign death_time                   = death_q;
    assign is_red_scared                = scared_q[RED];
    assign is_orange_scared             = scared_q[ORANGE];
    assign is_cyan_scared               = scared_q[CYAN];
    assign is_pink_scared               = scared_q[PINK];
    assign respawn                      = respawn_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Self-checking bench: behavioural model compared every cycle, plus directed
// literal checks and a randomized phase.
module tb_anim_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       pac_moving = 1'b0;
    logic [3:0] ghost_moving = 4'd0;
    logic       pac_caught = 1'b0;
    logic       scared_start = 1'b0;
    logic [3:0] ghost_eaten = 4'd0;
    logic [6:0] animation_count, red_c, orange_c, cyan_c, pink_c, death_time;
    logic       dying, respawn, s_red, s_orange, s_cyan, s_pink;

    int total = 0;
    int bad = 0;
    int resp_seen = 0;

    anim_sequencer dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .pac_moving(pac_moving), .ghost_moving(ghost_moving),
        .pac_caught(pac_caught), .scared_start(scared_start), .ghost_eaten(ghost_eaten),
        .animation_count(animation_count),
        .red_ghost_animation_count(red_c), .orange_ghost_animation_count(orange_c),
        .cyan_ghost_animation_count(cyan_c), .pink_ghost_animation_count(pink_c),
        .dying(dying), .death_time(death_time),
        .is_red_scared(s_red), .is_orange_scared(s_orange),
        .is_cyan_scared(s_cyan), .is_pink_scared(s_pink),
        .respawn(respawn)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [4:0] fh = '0;      // frame_clk samples, [0] = this edge, [k] = k edges ago
    logic       m_tick;
    int         m_pac = 0, m_death = 0, m_timer = 0;
    int         m_ghost [4] = '{0, 0, 0, 0};
    bit         m_dying = 0, m_respawn = 0;
    logic [3:0] m_scared = '0;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fh = '0; m_pac = 0; m_death = 0; m_timer = 0; m_dying = 0; m_respawn = 0;
            m_scared = '0;
            for (int i = 0; i < 4; i++) m_ghost[i] = 0;
        end else begin
            fh = {fh[3:0], frame_clk};
            m_tick = fh[3] & ~fh[4];   // rise seen three edges ago -> tick acts now
            if (m_respawn) begin
                m_respawn = 0;
            end else if (m_dying) begin
                if (m_tick) begin
                    if (m_death == 0) begin m_dying = 0; m_respawn = 1; end
                    else m_death = m_death - 1;
                end
            end else if (pac_caught) begin
                m_dying = 1; m_death = 100; m_pac = 0; m_timer = 0; m_scared = '0;
            end else begin
                if (m_tick) begin
                    if (pac_moving) m_pac = (m_pac + 1) % 6;
                    for (int i = 0; i < 4; i++)
                        if (ghost_moving[i]) m_ghost[i] = (m_ghost[i] + 1) % 6;
                end
                if (scared_start) begin
                    m_timer = 120; m_scared = 4'hF;
                end else begin
                    if (m_tick && m_timer > 0) begin
                        m_timer = m_timer - 1;
                        if (m_timer == 0) m_scared = '0;
                    end
                    m_scared = m_scared & ~ghost_eaten;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge Clk) begin
        chk("cyc_anim", animation_count, m_pac);
        chk("cyc_red", red_c, m_ghost[0]);
        chk("cyc_orange", orange_c, m_ghost[1]);
        chk("cyc_cyan", cyan_c, m_ghost[2]);
        chk("cyc_pink", pink_c, m_ghost[3]);
        chk("cyc_dying", dying, m_dying);
        chk("cyc_death", death_time, m_death);
        chk("cyc_respawn", respawn, m_respawn);
        chk("cyc_scared", {s_pink, s_cyan, s_orange, s_red}, m_scared);
    end

    // ---------------- stimulus helpers ----------------
    task automatic frame();
        @(negedge Clk); #1 frame_clk = 1'b1;
        repeat (3) begin @(negedge Clk); if (respawn) resp_seen++; end
        #1 frame_clk = 1'b0;
        repeat (3) begin @(negedge Clk); if (respawn) resp_seen++; end
        #1;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    task automatic pulse(input logic pc, input logic ss, input logic [3:0] ge);
        @(negedge Clk); #1 pac_caught = pc; scared_start = ss; ghost_eaten = ge;
        @(negedge Clk); #1 pac_caught = 1'b0; scared_start = 1'b0; ghost_eaten = 4'd0;
    endtask

    int exp_anim [7] = '{1, 2, 3, 4, 5, 0, 1};
    int fc_cnt;

    initial begin
        // reset state
        repeat (3) @(negedge Clk);
        chk("rst_anim", animation_count, 0);
        chk("rst_dying", dying, 0);
        chk("rst_scared", {s_pink, s_cyan, s_orange, s_red}, 0);
        #1 Reset_n = 1'b1;

        // 1: Pac-Man animation wraps at 5 -> 0; still ghosts hold
        pac_moving = 1'b1;
        for (int k = 0; k < 7; k++) begin
            frame();
            chk("t1_anim", animation_count, exp_anim[k]);
        end
        chk("t1_ghost", {red_c, orange_c, cyan_c, pink_c}, 0);

        // 3: death sequence
        pulse(1'b1, 1'b0, 4'd0);
        chk("t3_dying", dying, 1);
        chk("t3_load", death_time, 100);
        frames(100);
        chk("t3_zero", death_time, 0);
        chk("t3_still_dying", dying, 1);
        resp_seen = 0;
        frame();
        chk("t3_respawn_cycles", resp_seen, 1);
        chk("t3_alive", dying, 0);

        // 2: asynchronous reset mid-death
        pulse(1'b1, 1'b0, 4'd0);
        frames(43);
        chk("t2_death57", death_time, 57);
        @(posedge Clk); #2 Reset_n = 1'b0;
        #1;
        chk("t2_async_dying", dying, 0);
        chk("t2_async_death", death_time, 0);
        chk("t2_async_anim", animation_count, 0);
        @(negedge Clk); #1 Reset_n = 1'b1;

        // 4: eaten ghost loses its flag, others time out on tick 120
        pulse(1'b0, 1'b1, 4'd0);
        chk("t4_all_scared", {s_pink, s_cyan, s_orange, s_red}, 4'hF);
        pulse(1'b0, 1'b0, 4'b0001);
        chk("t4_red_eaten", {s_pink, s_cyan, s_orange, s_red}, 4'hE);
        frames(119);
        chk("t4_tick119", {s_pink, s_cyan, s_orange, s_red}, 4'hE);
        frame();
        chk("t4_tick120", {s_pink, s_cyan, s_orange, s_red}, 0);

        // 5: reload restarts the full duration
        pulse(1'b0, 1'b1, 4'd0);
        frames(60);
        pulse(1'b0, 1'b1, 4'd0);
        frames(119);
        chk("t5_still_scared", s_pink, 1);
        frame();
        chk("t5_cleared", s_pink, 0);

        // 6: capture beats a simultaneous pellet; animation frozen while dying
        pulse(1'b0, 1'b1, 4'd0);
        pulse(1'b1, 1'b1, 4'd0);
        chk("t6_dying", dying, 1);
        chk("t6_scared", {s_pink, s_cyan, s_orange, s_red}, 0);
        pac_moving = 1'b1;
        frames(3);
        chk("t6_anim_frozen", animation_count, 0);

        // randomized phase, model-checked every cycle
        fc_cnt = 4;
        for (int c = 0; c < 4000; c++) begin
            @(negedge Clk); #1;
            fc_cnt--;
            if (fc_cnt <= 0) begin
                frame_clk = ~frame_clk;
                fc_cnt = $urandom_range(1, 6);
            end
            pac_moving   = 1'($urandom);
            ghost_moving = 4'($urandom);
            pac_caught   = ($urandom % 150) == 0;
            scared_start = ($urandom % 40) == 0;
            ghost_eaten  = (($urandom % 20) == 0) ? 4'($urandom) : 4'd0;
            Reset_n      = !(c >= 2000 && c < 2002);
        end
        @(negedge Clk); #1;
        pac_caught = 1'b0; scared_start = 1'b0; ghost_eaten = 4'd0;
        repeat (4) @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
